// File: rtl/conv_pool_writeback_if.sv
// conv_pool_writeback_if: pixel stream into the pooling stage and the
// pooled write bus out of it.
//   pix_valid_in / pix_data_in             : raster-order pixel stream, one per strobe
//   wr_en_out / wr_addr_out / wr_data_out  : addressed pooled write transactions
// Modports:
//   master : the side that produces pixels and observes writes (bench / upstream)
//   slave  : the pooling stage
interface conv_pool_writeback_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MaxAddrWidth = 32
);
  logic                    pix_valid_in;
  logic [DataWidth-1:0]    pix_data_in;
  logic                    wr_en_out;
  logic [MaxAddrWidth-1:0] wr_addr_out;
  logic [DataWidth-1:0]    wr_data_out;

  modport master (
    output pix_valid_in, pix_data_in,
    input  wr_en_out, wr_addr_out, wr_data_out
  );

  modport slave (
    input  pix_valid_in, pix_data_in,
    output wr_en_out, wr_addr_out, wr_data_out
  );
endinterface

// File: rtl/conv_pool_writeback.sv
// conv_pool_writeback: 2x2 stride-2 signed max pooling over a square SxS raster
// pixel stream, emitting addressed writes of the floor(S/2) x floor(S/2) pooled map.
// Optional ReLU on every input pixel is enabled by defining CONV_POOL_RELU_EN.
// Ports:
//   Clk, Rst_n        : clock (rising edge), asynchronous active-low reset
//   start_in          : one-cycle pulse, latches out_size_in / out_base_addr_in
//   out_size_in       : frame width S
//   out_base_addr_in  : base address of the pooled map
//   bus (slave)       : pixel stream in, pooled write bus out
//   busy_out          : high while a frame is in progress
//   done_out          : one-cycle pulse when the last pixel has been accepted
//   err_out           : sticky protocol error, cleared by the next accepted start
module conv_pool_writeback #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MaxAddrWidth = 32,
  parameter int unsigned MaxPictWidth = 9,
  parameter int unsigned LineDepth    = 256
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    start_in,
  input  logic [MaxPictWidth-1:0] out_size_in,
  input  logic [MaxAddrWidth-1:0] out_base_addr_in,
  conv_pool_writeback_if.slave    bus,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    err_out
);

  localparam int unsigned LineAw = (LineDepth > 1) ? $clog2(LineDepth) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [MaxPictWidth-1:0] size_q, size_d;
  logic [MaxPictWidth-1:0] col_q, col_d;
  logic [MaxPictWidth-1:0] row_q, row_d;
  logic [MaxAddrWidth-1:0] base_q, base_d;
  logic [MaxAddrWidth-1:0] row_base_q, row_base_d;
  logic [DataWidth-1:0]    hold_q, hold_d;
  logic                    wr_en_q, wr_en_d;
  logic [MaxAddrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [DataWidth-1:0]    wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // Horizontal pair maxima of the most recent even row.
  logic [DataWidth-1:0]    line_mem [LineDepth];

  logic                    accept;
  logic [DataWidth-1:0]    pix_v;
  logic                    last_col;
  logic                    last_row;
  logic [MaxPictWidth-1:0] pool_lim;
  logic                    in_pool;
  logic [LineAw-1:0]       line_idx;
  logic [DataWidth-1:0]    line_rd;
  logic [DataWidth-1:0]    hmax;
  logic [DataWidth-1:0]    pool_max;
  logic                    line_we;

  assign accept = (state_q == StRun) && bus.pix_valid_in;

`ifdef CONV_POOL_RELU_EN
  assign pix_v = bus.pix_data_in[DataWidth-1] ? '0 : bus.pix_data_in;
`else
  assign pix_v = bus.pix_data_in;
`endif

  assign last_col = (col_q == size_q - MaxPictWidth'(1));
  assign last_row = (row_q == size_q - MaxPictWidth'(1));

  // Largest even size <= S: the trailing column/row of an odd frame (and the
  // whole frame when S < 2) falls outside it and is consumed without effect.
  assign pool_lim = {size_q[MaxPictWidth-1:1], 1'b0};
  assign in_pool  = (col_q < pool_lim) && (row_q < pool_lim);

  assign line_idx = LineAw'(col_q >> 1);
  assign line_rd  = line_mem[line_idx];
  assign hmax     = ($signed(hold_q) > $signed(pix_v)) ? hold_q : pix_v;
  assign pool_max = ($signed(line_rd) > $signed(hmax)) ? line_rd : hmax;
  assign line_we  = accept && in_pool && col_q[0] && !row_q[0];

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    base_d     = base_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    hold_d     = hold_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d    = StRun;
          size_d     = out_size_in;
          base_d     = out_base_addr_in;
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          err_d      = 1'b0;
        end
        // A pixel with no frame open is dropped and flagged.
        if (bus.pix_valid_in) begin
          err_d = 1'b1;
        end
      end
      StRun: begin
        if (start_in) begin
          err_d = 1'b1;
        end
        if (accept) begin
          if (in_pool && !col_q[0]) begin
            hold_d = pix_v;
          end
          if (in_pool && col_q[0] && row_q[0]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + row_base_q + MaxAddrWidth'(col_q >> 1);
            wr_data_d = pool_max;
          end
          if (last_col) begin
            col_d = '0;
            row_d = row_q + MaxPictWidth'(1);
            if (row_q[0]) begin
              row_base_d = row_base_q + MaxAddrWidth'(size_q >> 1);
            end
            if (last_row) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            col_d = col_q + MaxPictWidth'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      size_q     <= '0;
      base_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      hold_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      base_q     <= base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      hold_q     <= hold_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // No reset: every entry is rewritten on an even row before an odd row reads it.
  always_ff @(posedge Clk) begin
    if (line_we) begin
      line_mem[line_idx] <= hmax;
    end
  end

  assign bus.wr_en_out   = wr_en_q;
  assign bus.wr_addr_out = wr_addr_q;
  assign bus.wr_data_out = wr_data_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign err_out         = err_q;

endmodule
